// File: rtl/ariane_axi.sv
// AXI4+ATOP channel types and arbiter state enums shared by the ariane_axi blocks.
package ariane_axi;

    localparam int unsigned IdWidth      = 4;
    localparam int unsigned AddrWidth    = 64;
    localparam int unsigned DataWidth    = 64;
    localparam int unsigned StrbWidth    = DataWidth / 8;
    localparam int unsigned UserWidth    = 1;
    localparam int unsigned MaxNrMasters = 4;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [3:0]           qos;
        logic [3:0]           region;
        logic [5:0]           atop;
        logic [UserWidth-1:0] user;
    } aw_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [StrbWidth-1:0] strb;
        logic                 last;
        logic [UserWidth-1:0] user;
    } w_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [1:0]           resp;
        logic [UserWidth-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [3:0]           qos;
        logic [3:0]           region;
        logic [UserWidth-1:0] user;
    } ar_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
        logic                 last;
        logic [UserWidth-1:0] user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_BUSY, W_RESP} wr_state_e;

endpackage

// File: rtl/ariane_axi_rr_pick.sv
// Combinational round-robin pick: lowest requesting index at or above ptr, wrapping to 0.
module ariane_axi_rr_pick #(
    parameter int unsigned NrMasters = 2,
    localparam int unsigned IdxWidth = (NrMasters > 1) ? $clog2(NrMasters) : 1
) (
    input  logic [NrMasters-1:0] req,
    input  logic [IdxWidth-1:0]  ptr,
    output logic                 valid,
    output logic [IdxWidth-1:0]  idx
);

    localparam int unsigned SumWidth = IdxWidth + 1;

    logic [SumWidth-1:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < NrMasters; i++) begin
            cand = SumWidth'(ptr) + SumWidth'(i);
            if (cand >= SumWidth'(NrMasters)) begin
                cand = cand - SumWidth'(NrMasters);
            end
            if (!valid && req[cand[IdxWidth-1:0]]) begin
                valid = 1'b1;
                idx   = cand[IdxWidth-1:0];
            end
        end
    end

endmodule

// File: rtl/ariane_axi_serial_arbiter.sv
// Shares one AXI slave port among NrMasters masters; independent round-robin read
// and write paths, each with a single outstanding transaction and combinational pass-through.
module ariane_axi_serial_arbiter
    import ariane_axi::*;
#(
    parameter int unsigned NrMasters = 2
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  req_t  mst_req_i  [NrMasters],
    output resp_t mst_resp_o [NrMasters],
    output req_t  slv_req_o,
    input  resp_t slv_resp_i,
    output logic  rd_busy_o,
    output logic  wr_busy_o
);

    localparam int unsigned IdxWidth = (NrMasters > 1) ? $clog2(NrMasters) : 1;
    localparam int unsigned SumWidth = IdxWidth + 1;

    rd_state_e             rd_state;
    wr_state_e             wr_state;
    logic [IdxWidth-1:0]   rd_owner, rd_ptr, wr_owner, wr_ptr;
    logic                  aw_done, w_done;
    logic [NrMasters-1:0]  ar_req, aw_req;
    logic                  ar_pick_valid, aw_pick_valid;
    logic [IdxWidth-1:0]   ar_pick_idx, aw_pick_idx;
    logic                  ar_hs, r_last_hs, aw_hs, w_last_hs, b_hs;

    function automatic logic [IdxWidth-1:0] next_idx(input logic [IdxWidth-1:0] cur);
        logic [SumWidth-1:0] inc;
        inc = SumWidth'(cur) + SumWidth'(1);
        return (inc >= SumWidth'(NrMasters)) ? IdxWidth'(0) : IdxWidth'(inc);
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < NrMasters; i++) begin
            ar_req[i] = mst_req_i[i].ar_valid;
            aw_req[i] = mst_req_i[i].aw_valid;
        end
    end

    ariane_axi_rr_pick #(.NrMasters(NrMasters)) i_ar_pick (
        .req   (ar_req),
        .ptr   (rd_ptr),
        .valid (ar_pick_valid),
        .idx   (ar_pick_idx)
    );

    ariane_axi_rr_pick #(.NrMasters(NrMasters)) i_aw_pick (
        .req   (aw_req),
        .ptr   (wr_ptr),
        .valid (aw_pick_valid),
        .idx   (aw_pick_idx)
    );

    // Routing: payloads always follow the owners, handshakes only in the owning phase.
    always_comb begin
        slv_req_o    = '0;
        slv_req_o.ar = mst_req_i[rd_owner].ar;
        slv_req_o.aw = mst_req_i[wr_owner].aw;
        slv_req_o.w  = mst_req_i[wr_owner].w;
        for (int unsigned i = 0; i < NrMasters; i++) begin
            mst_resp_o[i]   = '0;
            mst_resp_o[i].r = slv_resp_i.r;
            mst_resp_o[i].b = slv_resp_i.b;
        end
        if (rd_state == R_ADDR) begin
            slv_req_o.ar_valid            = mst_req_i[rd_owner].ar_valid;
            mst_resp_o[rd_owner].ar_ready = slv_resp_i.ar_ready;
        end
        if (rd_state == R_DATA) begin
            slv_req_o.r_ready            = mst_req_i[rd_owner].r_ready;
            mst_resp_o[rd_owner].r_valid = slv_resp_i.r_valid;
        end
        if (wr_state == W_BUSY) begin
            if (!aw_done) begin
                slv_req_o.aw_valid            = mst_req_i[wr_owner].aw_valid;
                mst_resp_o[wr_owner].aw_ready = slv_resp_i.aw_ready;
            end
            if (!w_done) begin
                slv_req_o.w_valid            = mst_req_i[wr_owner].w_valid;
                mst_resp_o[wr_owner].w_ready = slv_resp_i.w_ready;
            end
        end
        if (wr_state == W_RESP) begin
            slv_req_o.b_ready            = mst_req_i[wr_owner].b_ready;
            mst_resp_o[wr_owner].b_valid = slv_resp_i.b_valid;
        end
    end

    assign ar_hs     = slv_req_o.ar_valid & slv_resp_i.ar_ready;
    assign r_last_hs = slv_resp_i.r_valid & slv_req_o.r_ready & slv_resp_i.r.last;
    assign aw_hs     = slv_req_o.aw_valid & slv_resp_i.aw_ready;
    assign w_last_hs = slv_req_o.w_valid & slv_resp_i.w_ready & slv_req_o.w.last;
    assign b_hs      = slv_resp_i.b_valid & slv_req_o.b_ready;

    assign rd_busy_o = (rd_state != R_IDLE);
    assign wr_busy_o = (wr_state != W_IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin : rd_fsm
        if (rst_i) begin
            rd_state <= R_IDLE;
            rd_owner <= '0;
            rd_ptr   <= '0;
        end else begin
            case (rd_state)
                R_IDLE: if (ar_pick_valid) begin
                    rd_owner <= ar_pick_idx;
                    rd_state <= R_ADDR;
                end
                R_ADDR: if (ar_hs) rd_state <= R_DATA;
                R_DATA: if (r_last_hs) begin
                    rd_state <= R_IDLE;
                    rd_ptr   <= next_idx(rd_owner);
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    // AW and W complete in either order; both flags must be seen before B.
    always_ff @(posedge clk_i or posedge rst_i) begin : wr_fsm
        if (rst_i) begin
            wr_state <= W_IDLE;
            wr_owner <= '0;
            wr_ptr   <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    if (aw_pick_valid) begin
                        wr_owner <= aw_pick_idx;
                        wr_state <= W_BUSY;
                    end
                end
                W_BUSY: begin
                    if (aw_hs)     aw_done <= 1'b1;
                    if (w_last_hs) w_done  <= 1'b1;
                    if ((aw_done || aw_hs) && (w_done || w_last_hs)) wr_state <= W_RESP;
                end
                W_RESP: if (b_hs) begin
                    wr_state <= W_IDLE;
                    wr_ptr   <= next_idx(wr_owner);
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ariane_axi_serial_arbiter.sv
// Directed bench for ariane_axi_serial_arbiter with two masters; inputs driven after the
// falling edge, outputs sampled 1 time unit later.
module tb_ariane_axi_serial_arbiter;
    import ariane_axi::*;

    localparam int unsigned NrMasters = 2;

    logic  clk = 1'b0;
    logic  rst;
    req_t  mst_req  [NrMasters];
    resp_t mst_resp [NrMasters];
    req_t  slv_req;
    resp_t slv_resp;
    logic  rd_busy, wr_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ariane_axi_serial_arbiter #(.NrMasters(NrMasters)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .mst_req_i  (mst_req),
        .mst_resp_o (mst_resp),
        .slv_req_o  (slv_req),
        .slv_resp_i (slv_resp),
        .rd_busy_o  (rd_busy),
        .wr_busy_o  (wr_busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        mst_req[0] = '0;
        mst_req[1] = '0;
        slv_resp   = '0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Entered just after a falling edge with the read path expected in R_ADDR for 'own'.
    task automatic rd_serve(input int own, input logic [63:0] addr, input int beats);
        int oth;
        oth = 1 - own;
        #1;
        check("ar_valid", 64'(slv_req.ar_valid), 64'(1));
        check("ar_addr", slv_req.ar.addr, addr);
        slv_resp.ar_ready = 1'b1;
        #1;
        check("ar_ready_own", 64'(mst_resp[own].ar_ready), 64'(1));
        check("ar_ready_oth", 64'(mst_resp[oth].ar_ready), 64'(0));
        @(negedge clk);
        slv_resp.ar_ready     = 1'b0;
        mst_req[own].ar_valid = 1'b0;
        mst_req[own].r_ready  = 1'b1;
        for (int b = 0; b < beats; b++) begin
            slv_resp.r_valid = 1'b1;
            slv_resp.r.data  = addr + 64'(b);
            slv_resp.r.last  = (b == beats - 1);
            #1;
            check("r_valid_own", 64'(mst_resp[own].r_valid), 64'(1));
            check("r_valid_oth", 64'(mst_resp[oth].r_valid), 64'(0));
            check("r_data", mst_resp[own].r.data, addr + 64'(b));
            check("r_last", 64'(mst_resp[own].r.last), 64'(b == beats - 1));
            check("slv_r_ready", 64'(slv_req.r_ready), 64'(1));
            @(negedge clk);
        end
        slv_resp.r_valid     = 1'b0;
        slv_resp.r.last      = 1'b0;
        mst_req[own].r_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        check("rst_ar_valid", 64'(slv_req.ar_valid), 64'(0));
        check("rst_aw_valid", 64'(slv_req.aw_valid), 64'(0));
        check("rst_w_valid", 64'(slv_req.w_valid), 64'(0));
        check("rst_r_ready", 64'(slv_req.r_ready), 64'(0));
        check("rst_b_ready", 64'(slv_req.b_ready), 64'(0));
        check("rst_rd_busy", 64'(rd_busy), 64'(0));
        check("rst_wr_busy", 64'(wr_busy), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        // Single 4-beat read by M0
        mst_req[0].ar_valid  = 1'b1;
        mst_req[0].ar.addr   = 64'h0000_0000_8000_0000;
        mst_req[0].ar.len    = 8'd3;
        #1;
        check("rd_lat_ar_valid", 64'(slv_req.ar_valid), 64'(0));
        @(negedge clk);
        #1;
        check("rd_busy_grant", 64'(rd_busy), 64'(1));
        rd_serve(0, 64'h0000_0000_8000_0000, 4);
        #1;
        check("rd_busy_after", 64'(rd_busy), 64'(0));

        // Read contention from pointer 0
        pulse_reset();
        mst_req[0].ar_valid = 1'b1;
        mst_req[0].ar.addr  = 64'h100;
        mst_req[1].ar_valid = 1'b1;
        mst_req[1].ar.addr  = 64'h200;
        @(negedge clk);
        rd_serve(0, 64'h100, 1);
        #1;
        check("bubble_ar_valid", 64'(slv_req.ar_valid), 64'(0));
        @(negedge clk);
        rd_serve(1, 64'h200, 1);
        mst_req[0].ar_valid = 1'b1;
        mst_req[0].ar.addr  = 64'h300;
        mst_req[1].ar_valid = 1'b1;
        mst_req[1].ar.addr  = 64'h400;
        @(negedge clk);
        rd_serve(0, 64'h300, 1);
        @(negedge clk);
        rd_serve(1, 64'h400, 1);

        // Write by M1 with W ahead of AW
        mst_req[1].aw_valid = 1'b1;
        mst_req[1].aw.addr  = 64'h1000;
        mst_req[1].aw.id    = 4'd5;
        mst_req[1].aw.len   = 8'd0;
        mst_req[1].w_valid  = 1'b1;
        mst_req[1].w.data   = 64'hCAFE_F00D_1234_5678;
        mst_req[1].w.strb   = 8'hFF;
        mst_req[1].w.last   = 1'b1;
        mst_req[1].b_ready  = 1'b1;
        #1;
        check("wr_lat_aw_valid", 64'(slv_req.aw_valid), 64'(0));
        @(negedge clk);
        #1;
        check("wr_aw_valid", 64'(slv_req.aw_valid), 64'(1));
        check("wr_aw_id", 64'(slv_req.aw.id), 64'(5));
        check("wr_w_valid", 64'(slv_req.w_valid), 64'(1));
        check("wr_w_strb", 64'(slv_req.w.strb), 64'hFF);
        check("wr_w_data", slv_req.w.data, 64'hCAFE_F00D_1234_5678);
        check("wr_b_ready_busy", 64'(slv_req.b_ready), 64'(0));
        slv_resp.w_ready = 1'b1;
        #1;
        check("wr_w_ready_own", 64'(mst_resp[1].w_ready), 64'(1));
        check("wr_w_ready_oth", 64'(mst_resp[0].w_ready), 64'(0));
        check("wr_aw_ready_held", 64'(mst_resp[1].aw_ready), 64'(0));
        @(negedge clk);
        slv_resp.w_ready  = 1'b0;
        slv_resp.aw_ready = 1'b1;
        #1;
        check("wr_w_gated", 64'(slv_req.w_valid), 64'(0));
        check("wr_aw_ready_own", 64'(mst_resp[1].aw_ready), 64'(1));
        check("wr_aw_ready_oth", 64'(mst_resp[0].aw_ready), 64'(0));
        @(negedge clk);
        mst_req[1].aw_valid = 1'b0;
        mst_req[1].w_valid  = 1'b0;
        slv_resp.aw_ready   = 1'b0;
        slv_resp.b_valid    = 1'b1;
        slv_resp.b.id       = 4'd5;
        slv_resp.b.resp     = 2'b00;
        #1;
        check("wr_b_ready", 64'(slv_req.b_ready), 64'(1));
        check("wr_b_valid_own", 64'(mst_resp[1].b_valid), 64'(1));
        check("wr_b_valid_oth", 64'(mst_resp[0].b_valid), 64'(0));
        check("wr_b_id", 64'(mst_resp[1].b.id), 64'(5));
        check("wr_b_resp", 64'(mst_resp[1].b.resp), 64'(0));
        @(negedge clk);
        clear_inputs();
        #1;
        check("wr_busy_after", 64'(wr_busy), 64'(0));

        // M0 write and M1 read in flight together
        mst_req[0].aw_valid = 1'b1;
        mst_req[0].aw.addr  = 64'h2000;
        mst_req[0].w_valid  = 1'b1;
        mst_req[0].w.last   = 1'b1;
        mst_req[0].b_ready  = 1'b1;
        mst_req[1].ar_valid = 1'b1;
        mst_req[1].ar.addr  = 64'h3000;
        mst_req[1].r_ready  = 1'b1;
        @(negedge clk);
        #1;
        check("cc_ar_valid", 64'(slv_req.ar_valid), 64'(1));
        check("cc_aw_valid", 64'(slv_req.aw_valid), 64'(1));
        check("cc_busy", 64'({rd_busy, wr_busy}), 64'(3));
        slv_resp.ar_ready = 1'b1;
        slv_resp.aw_ready = 1'b1;
        slv_resp.w_ready  = 1'b1;
        #1;
        check("cc_aw_ready_m0", 64'(mst_resp[0].aw_ready), 64'(1));
        check("cc_ar_ready_m1", 64'(mst_resp[1].ar_ready), 64'(1));
        check("cc_ar_ready_m0", 64'(mst_resp[0].ar_ready), 64'(0));
        check("cc_aw_ready_m1", 64'(mst_resp[1].aw_ready), 64'(0));
        @(negedge clk);
        mst_req[0].aw_valid = 1'b0;
        mst_req[0].w_valid  = 1'b0;
        mst_req[1].ar_valid = 1'b0;
        slv_resp            = '0;
        slv_resp.r_valid    = 1'b1;
        slv_resp.r.last     = 1'b1;
        slv_resp.r.data     = 64'h5A5A;
        slv_resp.b_valid    = 1'b1;
        #1;
        check("cc_r_valid_m1", 64'(mst_resp[1].r_valid), 64'(1));
        check("cc_r_valid_m0", 64'(mst_resp[0].r_valid), 64'(0));
        check("cc_b_valid_m0", 64'(mst_resp[0].b_valid), 64'(1));
        check("cc_b_valid_m1", 64'(mst_resp[1].b_valid), 64'(0));
        @(negedge clk);
        clear_inputs();
        #1;
        check("cc_idle", 64'({rd_busy, wr_busy}), 64'(0));

        // Reset during beat 2 of a 4-beat M0 read
        mst_req[0].ar_valid = 1'b1;
        mst_req[0].ar.addr  = 64'h4000;
        mst_req[0].ar.len   = 8'd3;
        @(negedge clk);
        slv_resp.ar_ready = 1'b1;
        @(negedge clk);
        slv_resp.ar_ready   = 1'b0;
        mst_req[0].ar_valid = 1'b0;
        mst_req[0].r_ready  = 1'b1;
        slv_resp.r_valid    = 1'b1;
        @(negedge clk);
        #1;
        check("rb_beat2_valid", 64'(mst_resp[0].r_valid), 64'(1));
        rst = 1'b1;
        #1;
        check("rb_r_valid", 64'(mst_resp[0].r_valid), 64'(0));
        check("rb_r_ready", 64'(slv_req.r_ready), 64'(0));
        check("rb_ar_valid", 64'(slv_req.ar_valid), 64'(0));
        check("rb_rd_busy", 64'(rd_busy), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        mst_req[1].ar_valid = 1'b1;
        mst_req[1].ar.addr  = 64'h5000;
        #1;
        check("rb_lat_ar_valid", 64'(slv_req.ar_valid), 64'(0));
        @(negedge clk);
        rd_serve(1, 64'h5000, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
